// File: rtl/ysyx_23060111_mem_arbiter_if.sv
// Bundles the handshake and bus signals around the memory arbiter. It covers
// two requester ports (IFU, LSU) and the single shared memory port.
//   master : the arbiter's view. Requests come in from IFU/LSU, and the
//            arbiter drives the memory request and the responses.
//   slave  : the surrounding system's view (requesters plus memory).
interface ysyx_23060111_mem_arbiter_if;
   logic        ifu_req_valid;
   logic        ifu_req_ready;
   logic [31:0] ifu_addr;
   logic        ifu_resp_valid;
   logic [31:0] ifu_rdata;
   logic        ifu_resp_err;

   logic        lsu_req_valid;
   logic        lsu_req_ready;
   logic [31:0] lsu_addr;
   logic        lsu_wen;
   logic [31:0] lsu_wdata;
   logic [3:0]  lsu_wmask;
   logic        lsu_resp_valid;
   logic [31:0] lsu_rdata;
   logic        lsu_resp_err;

   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_addr;
   logic        mem_wen;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_resp_valid;
   logic [31:0] mem_rdata;

   modport master (
      input  ifu_req_valid, ifu_addr,
      output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
      input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
      output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
      output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
      input  mem_req_ready, mem_resp_valid, mem_rdata
   );

   modport slave (
      output ifu_req_valid, ifu_addr,
      input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
      output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
      input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
      input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
      output mem_req_ready, mem_resp_valid, mem_rdata
   );
endinterface

// File: rtl/ysyx_23060111_mem_arbiter.sv
// Two-requester memory arbiter and transaction sequencer. It shares the one
// memory port between instruction fetch (IFU) and load/store (LSU), with one
// transaction outstanding at a time.
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : IFU/LSU request+response ports and the memory port (master view)
//   busy : high whenever a transaction is outstanding (state != IDLE)
// TIMEOUT sets the number of cycles from issue to response before the arbiter
// aborts with an error response. 0 disables the timeout.
module ysyx_23060111_mem_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                               clk,
   input  logic                               rst,
   ysyx_23060111_mem_arbiter_if.master        bus,
   output logic                               busy
);
   localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TLIM = TW'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t        state, state_nxt;
   logic          owner_lsu;   // owner of the outstanding transaction
   logic          last_lsu;    // last grant went to LSU
   logic [TW-1:0] timer;
   logic          grant_ifu, grant_lsu;
   logic          done_ok, timed_out, limit_hit;

   always_comb begin
      state_nxt = state;
      grant_ifu = 1'b0;
      grant_lsu = 1'b0;
      done_ok   = 1'b0;
      timed_out = 1'b0;
      limit_hit = (TIMEOUT != 0) && (timer == TLIM);
      case (state)
         IDLE: begin
            // A tie goes to whichever side was not granted last. Ready is
            // gated by rst so every output reads 0 while reset is held.
            grant_lsu = !rst && bus.lsu_req_valid && (!bus.ifu_req_valid || !last_lsu);
            grant_ifu = !rst && bus.ifu_req_valid && !grant_lsu;
            if (grant_ifu || grant_lsu) state_nxt = ISSUE;
         end
         ISSUE: begin
            if (bus.mem_req_ready) begin
               state_nxt = WAIT;
            end else if (limit_hit) begin
               timed_out = 1'b1;
               state_nxt = IDLE;
            end
         end
         WAIT: begin
            // A response arriving in the same cycle as the limit wins.
            if (bus.mem_resp_valid) begin
               done_ok   = 1'b1;
               state_nxt = IDLE;
            end else if (limit_hit) begin
               timed_out = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      bus.ifu_req_ready = grant_ifu;
      bus.lsu_req_ready = grant_lsu;
      bus.mem_req_valid = (state == ISSUE);
      busy              = (state != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state              <= IDLE;
         owner_lsu          <= 1'b0;
         last_lsu           <= 1'b0;
         timer              <= '0;
         bus.mem_addr       <= '0;
         bus.mem_wen        <= 1'b0;
         bus.mem_wdata      <= '0;
         bus.mem_wmask      <= '0;
         bus.ifu_resp_valid <= 1'b0;
         bus.ifu_rdata      <= '0;
         bus.ifu_resp_err   <= 1'b0;
         bus.lsu_resp_valid <= 1'b0;
         bus.lsu_rdata      <= '0;
         bus.lsu_resp_err   <= 1'b0;
      end else begin
         state              <= state_nxt;
         bus.ifu_resp_valid <= 1'b0;
         bus.ifu_resp_err   <= 1'b0;
         bus.lsu_resp_valid <= 1'b0;
         bus.lsu_resp_err   <= 1'b0;

         if (grant_ifu || grant_lsu) begin
            owner_lsu     <= grant_lsu;
            last_lsu      <= grant_lsu;
            timer         <= '0;
            bus.mem_addr  <= grant_lsu ? bus.lsu_addr : bus.ifu_addr;
            bus.mem_wen   <= grant_lsu && bus.lsu_wen;
            bus.mem_wdata <= grant_lsu ? bus.lsu_wdata : '0;
            bus.mem_wmask <= grant_lsu ? bus.lsu_wmask : '0;
         end else if (state != IDLE && timer != '1) begin
            timer <= timer + 1'b1;
         end

         if (done_ok) begin
            if (owner_lsu) begin
               bus.lsu_resp_valid <= 1'b1;
               bus.lsu_rdata      <= bus.mem_wen ? '0 : bus.mem_rdata;
            end else begin
               bus.ifu_resp_valid <= 1'b1;
               bus.ifu_rdata      <= bus.mem_rdata;
            end
         end else if (timed_out) begin
            if (owner_lsu) begin
               bus.lsu_resp_valid <= 1'b1;
               bus.lsu_resp_err   <= 1'b1;
               bus.lsu_rdata      <= '0;
            end else begin
               bus.ifu_resp_valid <= 1'b1;
               bus.ifu_resp_err   <= 1'b1;
               bus.ifu_rdata      <= '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_ysyx_23060111_mem_arbiter.sv
// Directed testbench for ysyx_23060111_mem_arbiter (TIMEOUT = 8).
// Inputs are driven 2 time units after the rising edge. Combinational
// outputs are checked 1 unit after driving, and registered outputs just
// after the edge.
module tb_ysyx_23060111_mem_arbiter;
   logic clk;
   logic rst;
   logic busy;
   int   errors = 0;
   int   checks = 0;

   ysyx_23060111_mem_arbiter_if bus ();

   ysyx_23060111_mem_arbiter #(.TIMEOUT(8)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus.master),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      bus.ifu_req_valid  = 1'b0;
      bus.ifu_addr       = '0;
      bus.lsu_req_valid  = 1'b0;
      bus.lsu_addr       = '0;
      bus.lsu_wen        = 1'b0;
      bus.lsu_wdata      = '0;
      bus.lsu_wmask      = '0;
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_rdata      = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      bus.ifu_req_valid = 1'b1;
      bus.lsu_req_valid = 1'b1;
      #3;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
      checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_req_valid: got %b expected 0", bus.mem_req_valid); end
      checks++; if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b expected 00", {bus.ifu_req_ready, bus.lsu_req_ready}); end
      checks++; if ({bus.ifu_resp_valid, bus.lsu_resp_valid, bus.ifu_resp_err, bus.lsu_resp_err} !== 4'b0000) begin errors++; $display("FAIL rst_resp: got %b expected 0000", {bus.ifu_resp_valid, bus.lsu_resp_valid, bus.ifu_resp_err, bus.lsu_resp_err}); end
      checks++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_wmask, bus.mem_wen} !== 69'd0) begin errors++; $display("FAIL rst_mem_regs: got %h expected 0", {bus.mem_addr, bus.mem_wdata, bus.mem_wmask, bus.mem_wen}); end
      checks++; if ({bus.ifu_rdata, bus.lsu_rdata} !== 64'd0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", {bus.ifu_rdata, bus.lsu_rdata}); end
      step();
      step();
      bus.ifu_req_valid = 1'b0;
      bus.lsu_req_valid = 1'b0;
      rst = 1'b0;
      step();
   endtask

   // Both requesters valid continuously; grants must alternate LSU, IFU, ...
   task automatic test_contention();
      logic exp_lsu;
      bus.ifu_req_valid = 1'b1;
      bus.ifu_addr      = 32'h8000_0100;
      bus.lsu_req_valid = 1'b1;
      bus.lsu_addr      = 32'h8000_2000;
      bus.lsu_wen       = 1'b0;
      bus.lsu_wmask     = 4'b1111;
      bus.mem_req_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_lsu = (i % 2 == 0);
         bus.mem_resp_valid = 1'b0;
         #1;
         checks++; if ({bus.lsu_req_ready, bus.ifu_req_ready} !== {exp_lsu, !exp_lsu}) begin errors++; $display("FAIL cont_grant%0d: got lsu,ifu=%b expected %b", i, {bus.lsu_req_ready, bus.ifu_req_ready}, {exp_lsu, !exp_lsu}); end
         step();
         checks++; if (bus.mem_addr !== (exp_lsu ? 32'h8000_2000 : 32'h8000_0100)) begin errors++; $display("FAIL cont_addr%0d: got %h expected %h", i, bus.mem_addr, exp_lsu ? 32'h8000_2000 : 32'h8000_0100); end
         step();
         bus.mem_resp_valid = 1'b1;
         bus.mem_rdata      = 32'hA000_0000 + 32'(i);
         step();
         checks++; if ({bus.lsu_resp_valid, bus.ifu_resp_valid} !== {exp_lsu, !exp_lsu}) begin errors++; $display("FAIL cont_resp%0d: got lsu,ifu=%b expected %b", i, {bus.lsu_resp_valid, bus.ifu_resp_valid}, {exp_lsu, !exp_lsu}); end
         checks++; if ((exp_lsu ? bus.lsu_rdata : bus.ifu_rdata) !== 32'hA000_0000 + 32'(i)) begin errors++; $display("FAIL cont_rdata%0d: got %h expected %h", i, exp_lsu ? bus.lsu_rdata : bus.ifu_rdata, 32'hA000_0000 + 32'(i)); end
      end
      bus.ifu_req_valid  = 1'b0;
      bus.lsu_req_valid  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_req_ready  = 1'b0;
      step();
   endtask

   task automatic test_ifu_read();
      bus.ifu_req_valid = 1'b1;
      bus.ifu_addr      = 32'h8000_0000;
      #1;
      checks++; if (bus.ifu_req_ready !== 1'b1) begin errors++; $display("FAIL ifu_ready: got %b expected 1", bus.ifu_req_ready); end
      step();                                   // N+1: ISSUE
      bus.ifu_req_valid = 1'b0;
      bus.mem_req_ready = 1'b1;
      checks++; if ({bus.mem_req_valid, busy} !== 2'b11) begin errors++; $display("FAIL ifu_issue: got valid,busy=%b expected 11", {bus.mem_req_valid, busy}); end
      checks++; if ({bus.mem_addr, bus.mem_wmask, bus.mem_wen} !== {32'h8000_0000, 4'b0000, 1'b0}) begin errors++; $display("FAIL ifu_mem_regs: got %h %b %b expected 80000000 0000 0", bus.mem_addr, bus.mem_wmask, bus.mem_wen); end
      step();                                   // N+2: WAIT
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b1;
      bus.mem_rdata      = 32'h0000_0413;
      checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL ifu_wait_valid: got %b expected 0", bus.mem_req_valid); end
      step();                                   // N+3: response
      bus.mem_resp_valid = 1'b0;
      checks++; if ({bus.ifu_resp_valid, bus.ifu_resp_err, bus.lsu_resp_valid, busy} !== 4'b1000) begin errors++; $display("FAIL ifu_resp: got v,err,lsu_v,busy=%b expected 1000", {bus.ifu_resp_valid, bus.ifu_resp_err, bus.lsu_resp_valid, busy}); end
      checks++; if (bus.ifu_rdata !== 32'h0000_0413) begin errors++; $display("FAIL ifu_rdata: got %h expected 00000413", bus.ifu_rdata); end
      step();
      checks++; if (bus.ifu_resp_valid !== 1'b0) begin errors++; $display("FAIL ifu_pulse_width: got %b expected 0", bus.ifu_resp_valid); end
   endtask

   task automatic test_lsu_store();
      bus.lsu_req_valid = 1'b1;
      bus.lsu_addr      = 32'h8000_1000;
      bus.lsu_wen       = 1'b1;
      bus.lsu_wdata     = 32'hDEAD_BEEF;
      bus.lsu_wmask     = 4'b1111;
      #1;
      checks++; if ({bus.lsu_req_ready, bus.ifu_req_ready} !== 2'b10) begin errors++; $display("FAIL st_ready: got %b expected 10", {bus.lsu_req_ready, bus.ifu_req_ready}); end
      step();
      // Scramble the request inputs: the registered mem_* side must not follow.
      bus.lsu_req_valid = 1'b0;
      bus.lsu_addr      = 32'h1111_1111;
      bus.lsu_wdata     = 32'h2222_2222;
      bus.lsu_wmask     = 4'b0101;
      bus.lsu_wen       = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) bus.mem_req_ready = 1'b1;
         checks++; if ({bus.mem_req_valid, bus.mem_wen, bus.mem_addr, bus.mem_wdata, bus.mem_wmask} !== {1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'b1111}) begin errors++; $display("FAIL st_hold%0d: got v=%b w=%b %h %h %b expected 1 1 80001000 deadbeef 1111", k, bus.mem_req_valid, bus.mem_wen, bus.mem_addr, bus.mem_wdata, bus.mem_wmask); end
         step();
      end
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b1;
      bus.mem_rdata      = 32'h1234_5678;
      step();
      bus.mem_resp_valid = 1'b0;
      checks++; if ({bus.lsu_resp_valid, bus.lsu_resp_err, bus.ifu_resp_valid} !== 3'b100) begin errors++; $display("FAIL st_resp: got lsu_v,err,ifu_v=%b expected 100", {bus.lsu_resp_valid, bus.lsu_resp_err, bus.ifu_resp_valid}); end
      checks++; if (bus.lsu_rdata !== 32'h0) begin errors++; $display("FAIL st_rdata: got %h expected 00000000", bus.lsu_rdata); end
      step();
   endtask

   task automatic test_timeout();
      bus.ifu_req_valid = 1'b1;
      bus.ifu_addr      = 32'h8000_0200;
      step();                                   // N+1: issue start
      bus.ifu_req_valid = 1'b0;
      bus.mem_req_ready = 1'b1;
      step();                                   // N+2: WAIT
      bus.mem_req_ready = 1'b0;
      for (int k = 2; k <= 9; k++) begin
         checks++; if ({bus.ifu_resp_valid, busy} !== 2'b01) begin errors++; $display("FAIL to_wait%0d: got resp,busy=%b expected 01", k, {bus.ifu_resp_valid, busy}); end
         step();
      end
      // N+10: nine cycles after issue start
      checks++; if ({bus.ifu_resp_valid, bus.ifu_resp_err, busy} !== 3'b110) begin errors++; $display("FAIL to_pulse: got v,err,busy=%b expected 110", {bus.ifu_resp_valid, bus.ifu_resp_err, busy}); end
      checks++; if (bus.ifu_rdata !== 32'h0) begin errors++; $display("FAIL to_rdata: got %h expected 00000000", bus.ifu_rdata); end
      bus.mem_resp_valid = 1'b1;
      bus.mem_rdata      = 32'hBAD0_BAD0;
      step();
      step();
      bus.mem_resp_valid = 1'b0;
      checks++; if ({bus.ifu_resp_valid, bus.lsu_resp_valid, bus.mem_req_valid, busy} !== 4'b0000) begin errors++; $display("FAIL to_late_resp: got %b expected 0000", {bus.ifu_resp_valid, bus.lsu_resp_valid, bus.mem_req_valid, busy}); end
      step();
   endtask

   task automatic test_reset_mid_wait();
      bus.lsu_req_valid = 1'b1;
      bus.lsu_addr      = 32'h8000_3000;
      bus.lsu_wen       = 1'b1;
      bus.lsu_wdata     = 32'h5555_AAAA;
      bus.lsu_wmask     = 4'b0011;
      step();
      bus.lsu_req_valid = 1'b0;
      bus.mem_req_ready = 1'b1;
      step();                                   // WAIT, last grant = LSU
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b1;
      rst = 1'b1;
      #1;
      checks++; if ({busy, bus.mem_req_valid, bus.mem_wen, bus.mem_wmask} !== 7'd0) begin errors++; $display("FAIL rmw_outputs: got %b expected 0000000", {busy, bus.mem_req_valid, bus.mem_wen, bus.mem_wmask}); end
      checks++; if ({bus.mem_addr, bus.mem_wdata} !== 64'd0) begin errors++; $display("FAIL rmw_mem_regs: got %h expected 0", {bus.mem_addr, bus.mem_wdata}); end
      step();
      bus.mem_resp_valid = 1'b0;
      rst = 1'b0;
      step();
      checks++; if ({bus.lsu_resp_valid, bus.ifu_resp_valid, busy} !== 3'b000) begin errors++; $display("FAIL rmw_no_resp: got %b expected 000", {bus.lsu_resp_valid, bus.ifu_resp_valid, busy}); end
      bus.ifu_req_valid = 1'b1;
      bus.lsu_req_valid = 1'b1;
      #1;
      checks++; if ({bus.lsu_req_ready, bus.ifu_req_ready} !== 2'b10) begin errors++; $display("FAIL rmw_tie: got lsu,ifu=%b expected 10", {bus.lsu_req_ready, bus.ifu_req_ready}); end
      bus.ifu_req_valid = 1'b0;
      bus.lsu_req_valid = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_contention();
      test_ifu_read();
      test_lsu_store();
      test_timeout();
      test_reset_mid_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
